// File: rtl/data_sram_responder.sv
// Data SRAM port responder: byte-writable on-chip RAM plus a small MMIO window
// holding a free-running timer with compare interrupt, LED and scratch registers.
module data_sram_responder #(
  parameter int          ADDR_WIDTH = 12,
  parameter logic [31:0] MMIO_BASE  = 32'hbfaf_0000
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        data_sram_en,
  input  logic [3:0]  data_sram_we,
  input  logic [31:0] data_sram_addr,
  input  logic [31:0] data_sram_wdata,
  output logic [31:0] data_sram_rdata,
  output logic        timer_int,
  output logic [15:0] led
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  logic [31:0]           mem_r [DEPTH];
  logic [31:0]           rdata_r;
  logic [31:0]           timer_r;
  logic [31:0]           tcmp_r;
  logic                  tctrl_en_r;
  logic                  pend_r;
  logic [15:0]           led_r;
  logic [31:0]           scratch_r;

  logic [ADDR_WIDTH-1:0] idx_s;
  logic [13:0]           off_s;
  logic                  is_mmio_s;
  logic                  ram_wr_s;
  logic                  mmio_wr_s;
  logic [31:0]           mmio_rdata_s;
  logic [31:0]           tcmp_nxt_s;
  logic [31:0]           led_nxt_s;
  logic [31:0]           scratch_nxt_s;
  logic                  tctrl_en_nxt_s;
  logic                  pend_set_s;
  logic                  pend_clr_s;
  logic                  unused_s;

  // Replace the enabled byte lanes of old_word with those of new_word.
  function automatic logic [31:0] merge_bytes(input logic [31:0] old_word,
                                              input logic [31:0] new_word,
                                              input logic [3:0]  be);
    logic [31:0] res;
    res = old_word;
    for (int i = 0; i < 4; i++) begin
      if (be[i]) res[8*i +: 8] = new_word[8*i +: 8];
    end
    return res;
  endfunction

  assign idx_s     = data_sram_addr[ADDR_WIDTH+1:2];
  assign off_s     = data_sram_addr[15:2];
  assign is_mmio_s = (data_sram_addr[31:16] == MMIO_BASE[31:16]);
  assign ram_wr_s  = data_sram_en & (|data_sram_we) & ~is_mmio_s;
  assign mmio_wr_s = data_sram_en & (|data_sram_we) & is_mmio_s;
  assign unused_s  = ^data_sram_addr[1:0];

  // Set uses the pre-write TCMP/en so a register write only affects later compares.
  assign pend_set_s = tctrl_en_r & (timer_r == tcmp_r);
  assign pend_clr_s = mmio_wr_s & (off_s == 14'h0002) & data_sram_we[0] & data_sram_wdata[1];

  // MMIO read mux, sampled in the request cycle.
  always_comb begin
    mmio_rdata_s = 32'h0000_0000;
    case (off_s)
      14'h0000: mmio_rdata_s = timer_r;
      14'h0001: mmio_rdata_s = tcmp_r;
      14'h0002: mmio_rdata_s = {30'd0, pend_r, tctrl_en_r};
      14'h0003: mmio_rdata_s = {16'd0, led_r};
      14'h0004: mmio_rdata_s = scratch_r;
      default:  mmio_rdata_s = 32'h0000_0000;
    endcase
  end

  // Next values of the writable MMIO registers.
  always_comb begin
    tcmp_nxt_s     = tcmp_r;
    led_nxt_s      = {16'd0, led_r};
    scratch_nxt_s  = scratch_r;
    tctrl_en_nxt_s = tctrl_en_r;
    if (mmio_wr_s) begin
      case (off_s)
        14'h0001: tcmp_nxt_s    = merge_bytes(tcmp_r, data_sram_wdata, data_sram_we);
        14'h0002: tctrl_en_nxt_s = data_sram_we[0] ? data_sram_wdata[0] : tctrl_en_r;
        14'h0003: led_nxt_s     = merge_bytes({16'd0, led_r}, data_sram_wdata, data_sram_we);
        14'h0004: scratch_nxt_s = merge_bytes(scratch_r, data_sram_wdata, data_sram_we);
        default:  tcmp_nxt_s    = tcmp_r;
      endcase
    end else begin
      tcmp_nxt_s = tcmp_r;
    end
  end

  // RAM array: not reset, written after the read-first sample.
  always_ff @(posedge clk) begin
    if (ram_wr_s) begin
      mem_r[idx_s] <= merge_bytes(mem_r[idx_s], data_sram_wdata, data_sram_we);
    end
  end

  // Read data and MMIO state registers.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rdata_r    <= 32'h0000_0000;
      timer_r    <= 32'h0000_0000;
      tcmp_r     <= 32'hffff_ffff;
      tctrl_en_r <= 1'b0;
      pend_r     <= 1'b0;
      led_r      <= 16'h0000;
      scratch_r  <= 32'h0000_0000;
    end else begin
      if (data_sram_en) begin
        rdata_r <= is_mmio_s ? mmio_rdata_s : mem_r[idx_s];
      end
      timer_r    <= timer_r + 32'd1;
      tcmp_r     <= tcmp_nxt_s;
      tctrl_en_r <= tctrl_en_nxt_s;
      pend_r     <= pend_set_s | (pend_r & ~pend_clr_s);
      led_r      <= led_nxt_s[15:0];
      scratch_r  <= scratch_nxt_s;
    end
  end

  assign data_sram_rdata = rdata_r;
  assign timer_int       = pend_r & tctrl_en_r;
  assign led             = led_r;

endmodule

// File: tb/tb_data_sram_responder.sv
// Randomized bench for data_sram_responder against a transaction-level model
// of the RAM and MMIO register file.
module tb_data_sram_responder;

  localparam logic [31:0] BASE = 32'hbfaf_0000;

  logic        clk = 1'b0;
  logic        resetn = 1'b1;
  logic        data_sram_en = 1'b0;
  logic [3:0]  data_sram_we = 4'h0;
  logic [31:0] data_sram_addr = 32'h0;
  logic [31:0] data_sram_wdata = 32'h0;
  logic [31:0] data_sram_rdata;
  logic        timer_int;
  logic [15:0] led;

  int vectors = 0;
  int miscompares = 0;

  logic [31:0] mem_m [4096];
  logic [31:0] rdata_m, timer_m, tcmp_m, scratch_m;
  logic [15:0] led_m;
  logic        en_m, pend_m;

  data_sram_responder dut (
    .clk             (clk),
    .resetn          (resetn),
    .data_sram_en    (data_sram_en),
    .data_sram_we    (data_sram_we),
    .data_sram_addr  (data_sram_addr),
    .data_sram_wdata (data_sram_wdata),
    .data_sram_rdata (data_sram_rdata),
    .timer_int       (timer_int),
    .led             (led)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    rdata_m = 32'h0; timer_m = 32'h0; tcmp_m = 32'hffff_ffff;
    en_m = 1'b0; pend_m = 1'b0; led_m = 16'h0; scratch_m = 32'h0;
  endtask

  // One clock edge of the reference behaviour.
  task automatic model_edge(input logic en, input logic [3:0] we, input logic [31:0] addr,
                            input logic [31:0] wd);
    logic        mmio;
    logic [13:0] off;
    int          idx;
    logic        set, clr, nen;
    mmio = (addr[31:16] == BASE[31:16]);
    off  = addr[15:2];
    idx  = int'(addr[13:2]);
    set  = en_m && (timer_m == tcmp_m);
    clr  = 1'b0;
    nen  = en_m;
    if (en) begin
      if (mmio) begin
        case (off)
          14'd0:   rdata_m = timer_m;
          14'd1:   rdata_m = tcmp_m;
          14'd2:   rdata_m = {30'd0, pend_m, en_m};
          14'd3:   rdata_m = {16'd0, led_m};
          14'd4:   rdata_m = scratch_m;
          default: rdata_m = 32'h0;
        endcase
      end else begin
        rdata_m = mem_m[idx];
      end
      for (int b = 0; b < 4; b++) begin
        if (we[b]) begin
          if (!mmio) mem_m[idx][8*b +: 8] = wd[8*b +: 8];
          else if (off == 14'd1) tcmp_m[8*b +: 8] = wd[8*b +: 8];
          else if (off == 14'd2 && b == 0) begin clr = wd[1]; nen = wd[0]; end
          else if (off == 14'd3 && b < 2) led_m[8*b +: 8] = wd[8*b +: 8];
          else if (off == 14'd4) scratch_m[8*b +: 8] = wd[8*b +: 8];
        end
      end
    end
    pend_m  = set | (pend_m & ~clr);
    en_m    = nen;
    timer_m = timer_m + 32'd1;
  endtask

  task automatic do_cycle(input logic en, input logic [3:0] we, input logic [31:0] addr,
                          input logic [31:0] wd);
    data_sram_en = en; data_sram_we = we; data_sram_addr = addr; data_sram_wdata = wd;
    @(posedge clk);
    model_edge(en, we, addr, wd);
    #1;
    check_eq("rdata", data_sram_rdata, rdata_m);
    check_eq("timer_int", {31'd0, timer_int}, {31'd0, pend_m & en_m});
    check_eq("led", {16'd0, led}, {16'd0, led_m});
  endtask

  task automatic apply_reset();
    resetn = 1'b0;
    data_sram_en = 1'b0; data_sram_we = 4'h0;
    #1;
    check_eq("rst_rdata", data_sram_rdata, 32'h0);
    check_eq("rst_irq", {31'd0, timer_int}, 32'h0);
    check_eq("rst_led", {16'd0, led}, 32'h0);
    repeat (2) @(posedge clk);
    #1;
    resetn = 1'b1;
    model_reset();
  endtask

  initial begin
    int cnt;
    logic [31:0] t0, a, w;
    logic [3:0]  we;
    logic [13:0] offs [7];
    offs = '{14'h0, 14'h1, 14'h2, 14'h3, 14'h4, 14'h5, 14'h8};
    model_reset();
    #2;
    apply_reset();

    // Timer value after 100 idle cycles, then hold while idle.
    repeat (100) do_cycle(1'b0, 4'h0, 32'h0, 32'h0);
    do_cycle(1'b1, 4'h0, BASE, 32'h0);
    check_eq("timer100", data_sram_rdata, 32'd100);
    repeat (3) do_cycle(1'b0, 4'h0, BASE, 32'h0);
    check_eq("timer_hold", data_sram_rdata, 32'd100);

    // Preload the RAM words used later.
    for (int i = 0; i < 18; i++)
      do_cycle(1'b1, 4'hf, 32'(i) << 2, (32'(i) * 32'h0101_0101) ^ 32'ha5a5_0000);

    do_cycle(1'b1, 4'hf, 32'h40, 32'h1234_5678);
    do_cycle(1'b1, 4'h0, 32'h40, 32'h0);
    check_eq("ram_full", data_sram_rdata, 32'h1234_5678);
    do_cycle(1'b1, 4'b0010, 32'h40, 32'h0000_ab00);
    do_cycle(1'b1, 4'h0, 32'h40, 32'h0);
    check_eq("ram_byte", data_sram_rdata, 32'h1234_ab78);
    do_cycle(1'b1, 4'hf, 32'h44, 32'hdead_beef);
    do_cycle(1'b1, 4'hf, 32'h44, 32'h1111_1111);
    check_eq("read_first", data_sram_rdata, 32'hdead_beef);
    do_cycle(1'b1, 4'hf, 32'h4000, 32'h1);
    do_cycle(1'b1, 4'h0, 32'h0, 32'h0);
    check_eq("alias", data_sram_rdata, 32'h1);
    do_cycle(1'b1, 4'hf, BASE + 32'h20, 32'hffff_ffff);
    do_cycle(1'b1, 4'h0, BASE + 32'h20, 32'h0);
    check_eq("unmapped", data_sram_rdata, 32'h0);

    // Compare interrupt: rises 20 edges after the TCMP write.
    t0 = timer_m;
    do_cycle(1'b1, 4'hf, BASE + 32'h4, t0 + 32'd20);
    do_cycle(1'b1, 4'hf, BASE + 32'h8, 32'h1);
    cnt = 1;
    while (!timer_int && cnt < 40) begin
      do_cycle(1'b0, 4'h0, 32'h0, 32'h0);
      cnt++;
    end
    check_eq("irq_delay", 32'(cnt), 32'd20);
    do_cycle(1'b1, 4'hf, BASE + 32'h8, 32'h3);
    check_eq("w1c", {31'd0, timer_int}, 32'h0);
    t0 = timer_m;
    do_cycle(1'b1, 4'hf, BASE + 32'h4, t0 + 32'd3);
    repeat (2) do_cycle(1'b0, 4'h0, 32'h0, 32'h0);
    do_cycle(1'b1, 4'hf, BASE + 32'h8, 32'h3);
    check_eq("set_wins", {31'd0, timer_int}, 32'h1);
    do_cycle(1'b1, 4'hf, BASE + 32'h8, 32'h0);
    check_eq("en_off_irq", {31'd0, timer_int}, 32'h0);
    do_cycle(1'b1, 4'h0, BASE + 32'h8, 32'h0);
    check_eq("pend_kept", data_sram_rdata, 32'h2);

    do_cycle(1'b1, 4'hf, BASE + 32'hc, 32'hffff_5a5a);
    check_eq("led_val", {16'd0, led}, 32'h5a5a);
    do_cycle(1'b1, 4'h0, BASE + 32'hc, 32'h0);
    check_eq("led_rd", data_sram_rdata, 32'h0000_5a5a);
    do_cycle(1'b1, 4'hf, 32'h8, 32'h7777_7777);
    do_cycle(1'b1, 4'h0, 32'h8, 32'h0);
    apply_reset();

    // Random traffic over RAM (with aliasing) and the MMIO window.
    for (int i = 0; i < 1500; i++) begin
      if (i == 700) apply_reset();
      we = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom);
      if ($urandom_range(0, 1) == 0) begin
        a = BASE | {16'd0, offs[$urandom_range(0, 6)], 2'($urandom)};
        w = ($urandom_range(0, 1) == 0) ? timer_m + 32'($urandom_range(0, 20)) : $urandom;
      end else begin
        a = (32'($urandom_range(0, 15)) << 14) | (32'($urandom_range(0, 17)) << 2)
            | 32'($urandom_range(0, 3));
        w = $urandom;
      end
      do_cycle(1'($urandom_range(0, 3) != 0), we, a, w);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
